// File: rtl/irrigation_valve_sequencer.sv
// Moore valve sequencer: sprinkler / drip / sprinkler-then-drip runs timed by a tick prescaler, then a holdoff.
// Optional IRR_RUN_COUNTER_EN adds a saturating run_count of completed runs.
module irrigation_valve_sequencer #(
   parameter int TICK_DIV   = 1000,
   parameter int SPR_TICKS  = 30,
   parameter int MIX_TICKS  = 22,
   parameter int DRIP_TICKS = 60,
   parameter int HOLD_TICKS = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] type_of_irrigation_state,
   input  logic       water_ok,
   input  logic       fault_clr,
   output logic       sprinkler_valve,
   output logic       drip_valve,
   output logic       pump_on,
   output logic       busy,
   output logic       error
`ifdef IRR_RUN_COUNTER_EN
   ,
   output logic [7:0] run_count
`endif
);

   localparam int MAX_A = (SPR_TICKS > MIX_TICKS) ? SPR_TICKS : MIX_TICKS;
   localparam int MAX_B = (DRIP_TICKS > HOLD_TICKS) ? DRIP_TICKS : HOLD_TICKS;
   localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int TW    = $clog2(MAX_T) + 1;
   localparam int PW    = $clog2(TICK_DIV) + 1;

   typedef enum logic [2:0] {
      IDLE, SPRINK, MIX_SPR, GAP, MIX_DRIP, DRIP, HOLD, FAULT
   } state_t;

   state_t          state, nxt;
   logic [PW-1:0]   presc;
   logic [TW-1:0]   tmr;
   logic [TW-1:0]   phase_last;
   logic            timed;
   logic            tick_done;
   logic            phase_done;
   logic            multi_hot;

   assign multi_hot  = |(type_of_irrigation_state & (type_of_irrigation_state - 3'd1));
   assign tick_done  = (presc == PW'(TICK_DIV - 1));
   assign phase_done = tick_done && (tmr == phase_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nxt;
      end
   end

   // Counters restart on every state entry and only run inside timed phases, so they never wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
         tmr   <= '0;
      end else if (nxt != state || !timed) begin
         presc <= '0;
         tmr   <= '0;
      end else if (tick_done) begin
         presc <= '0;
         tmr   <= tmr + TW'(1);
      end else begin
         presc <= presc + PW'(1);
      end
   end

   always_comb begin
      nxt        = state;
      timed      = 1'b0;
      phase_last = '0;
      case (state)
         IDLE: begin
            if (type_of_irrigation_state != 3'b000) begin
               if (!water_ok || multi_hot) begin
                  nxt = FAULT;
               end else if (type_of_irrigation_state == 3'b100) begin
                  nxt = SPRINK;
               end else if (type_of_irrigation_state == 3'b010) begin
                  nxt = DRIP;
               end else begin
                  nxt = MIX_SPR;
               end
            end
         end
         SPRINK: begin
            timed      = 1'b1;
            phase_last = TW'(SPR_TICKS - 1);
            if (!water_ok)       nxt = FAULT;
            else if (phase_done) nxt = HOLD;
         end
         MIX_SPR: begin
            timed      = 1'b1;
            phase_last = TW'(MIX_TICKS - 1);
            if (!water_ok)       nxt = FAULT;
            else if (phase_done) nxt = GAP;
         end
         GAP: begin
            if (!water_ok) nxt = FAULT;
            else           nxt = MIX_DRIP;
         end
         MIX_DRIP, DRIP: begin
            timed      = 1'b1;
            phase_last = TW'(DRIP_TICKS - 1);
            if (!water_ok)       nxt = FAULT;
            else if (phase_done) nxt = HOLD;
         end
         HOLD: begin
            timed      = 1'b1;
            phase_last = TW'(HOLD_TICKS - 1);
            if (phase_done) nxt = IDLE;
         end
         FAULT: begin
            if (fault_clr && water_ok) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      sprinkler_valve = 1'b0;
      drip_valve      = 1'b0;
      busy            = 1'b0;
      error           = 1'b0;
      case (state)
         SPRINK, MIX_SPR: begin
            sprinkler_valve = 1'b1;
            busy            = 1'b1;
         end
         MIX_DRIP, DRIP: begin
            drip_valve = 1'b1;
            busy       = 1'b1;
         end
         GAP, HOLD: busy  = 1'b1;
         FAULT:     error = 1'b1;
         default: ;
      endcase
   end

   assign pump_on = sprinkler_valve | drip_valve;

`ifdef IRR_RUN_COUNTER_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_count <= 8'd0;
      end else if (nxt == HOLD && state != HOLD && run_count != 8'hFF) begin
         run_count <= run_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_irrigation_valve_sequencer.sv
// Directed bench for irrigation_valve_sequencer with TICK_DIV=4, SPR=3, MIX=2, DRIP=3, HOLD=2.
module tb_irrigation_valve_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] type_of_irrigation_state;
   logic       water_ok;
   logic       fault_clr;
   logic       sprinkler_valve, drip_valve, pump_on, busy, error;
`ifdef IRR_RUN_COUNTER_EN
   logic [7:0] run_count;
`endif
   logic [4:0] obs;
   int         errors = 0;
   int         checks = 0;

   // {sprinkler, drip, pump, busy, error}
   localparam logic [4:0] V_IDLE = 5'b00000;
   localparam logic [4:0] V_SPR  = 5'b10110;
   localparam logic [4:0] V_DRIP = 5'b01110;
   localparam logic [4:0] V_OFF  = 5'b00010;
   localparam logic [4:0] V_FLT  = 5'b00001;

   assign obs = {sprinkler_valve, drip_valve, pump_on, busy, error};

   always #5 clk = ~clk;

   irrigation_valve_sequencer #(
      .TICK_DIV(4), .SPR_TICKS(3), .MIX_TICKS(2), .DRIP_TICKS(3), .HOLD_TICKS(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .type_of_irrigation_state(type_of_irrigation_state),
      .water_ok(water_ok),
      .fault_clr(fault_clr),
      .sprinkler_valve(sprinkler_valve),
      .drip_valve(drip_valve),
      .pump_on(pump_on),
      .busy(busy),
      .error(error)
`ifdef IRR_RUN_COUNTER_EN
      ,
      .run_count(run_count)
`endif
   );

   task automatic test_reset();
      rst_n = 1'b0;
      type_of_irrigation_state = 3'b000;
      water_ok = 1'b1;
      fault_clr = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (obs !== V_IDLE) begin
         errors++;
         $display("FAIL reset got=%b exp=%b", obs, V_IDLE);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== V_IDLE) begin
         errors++;
         $display("FAIL idle_after_reset got=%b exp=%b", obs, V_IDLE);
      end
   endtask

   // 12 sprinkler cycles, 8 hold cycles (water_ok dropped during hold is ignored), then idle.
   task automatic test_sprinkler();
      type_of_irrigation_state = 3'b100;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== V_SPR) begin
            errors++;
            $display("FAIL sprink[%0d] got=%b exp=%b", i, obs, V_SPR);
         end
         type_of_irrigation_state = 3'b000;
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== V_OFF) begin
            errors++;
            $display("FAIL sprink_hold[%0d] got=%b exp=%b", i, obs, V_OFF);
         end
         if (i == 2) water_ok = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (obs !== V_IDLE) begin
         errors++;
         $display("FAIL sprink_idle got=%b exp=%b", obs, V_IDLE);
      end
      water_ok = 1'b1;
   endtask

   task automatic test_mix();
      logic overlap;
      overlap = 1'b0;
      type_of_irrigation_state = 3'b001;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         overlap |= sprinkler_valve & drip_valve;
         checks++;
         if (obs !== V_SPR) begin
            errors++;
            $display("FAIL mix_spr[%0d] got=%b exp=%b", i, obs, V_SPR);
         end
         type_of_irrigation_state = 3'b000;
      end
      @(negedge clk);
      checks++;
      if (obs !== V_OFF) begin
         errors++;
         $display("FAIL mix_gap got=%b exp=%b", obs, V_OFF);
      end
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         overlap |= sprinkler_valve & drip_valve;
         checks++;
         if (obs !== V_DRIP) begin
            errors++;
            $display("FAIL mix_drip[%0d] got=%b exp=%b", i, obs, V_DRIP);
         end
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== V_OFF) begin
            errors++;
            $display("FAIL mix_hold[%0d] got=%b exp=%b", i, obs, V_OFF);
         end
      end
      @(negedge clk);
      checks++;
      if (obs !== V_IDLE) begin
         errors++;
         $display("FAIL mix_idle got=%b exp=%b", obs, V_IDLE);
      end
      checks++;
      if (overlap !== 1'b0) begin
         errors++;
         $display("FAIL mix_overlap got=%b exp=0", overlap);
      end
   endtask

   task automatic test_drip_fault();
      type_of_irrigation_state = 3'b010;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== V_DRIP) begin
            errors++;
            $display("FAIL drip[%0d] got=%b exp=%b", i, obs, V_DRIP);
         end
         type_of_irrigation_state = 3'b000;
      end
      water_ok = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== V_FLT) begin
         errors++;
         $display("FAIL drip_fault got=%b exp=%b", obs, V_FLT);
      end
      fault_clr = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== V_FLT) begin
         errors++;
         $display("FAIL fault_hold_dry got=%b exp=%b", obs, V_FLT);
      end
      water_ok = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== V_IDLE) begin
         errors++;
         $display("FAIL fault_clear got=%b exp=%b", obs, V_IDLE);
      end
      fault_clr = 1'b0;
   endtask

   // Phase expires on the same edge water_ok is seen low: fault must win over HOLD.
   task automatic test_expiry_fault();
      type_of_irrigation_state = 3'b100;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== V_SPR) begin
            errors++;
            $display("FAIL exp_spr[%0d] got=%b exp=%b", i, obs, V_SPR);
         end
         type_of_irrigation_state = 3'b000;
      end
      water_ok = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== V_FLT) begin
         errors++;
         $display("FAIL expiry_fault got=%b exp=%b", obs, V_FLT);
      end
      water_ok = 1'b1;
      fault_clr = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== V_IDLE) begin
         errors++;
         $display("FAIL expiry_clear got=%b exp=%b", obs, V_IDLE);
      end
      fault_clr = 1'b0;
   endtask

   task automatic test_bad_type();
      type_of_irrigation_state = 3'b110;
      @(negedge clk);
      checks++;
      if (obs !== V_FLT) begin
         errors++;
         $display("FAIL multihot got=%b exp=%b", obs, V_FLT);
      end
      type_of_irrigation_state = 3'b000;
      @(negedge clk);
      checks++;
      if (obs !== V_FLT) begin
         errors++;
         $display("FAIL multihot_stay got=%b exp=%b", obs, V_FLT);
      end
      fault_clr = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== V_IDLE) begin
         errors++;
         $display("FAIL multihot_clear got=%b exp=%b", obs, V_IDLE);
      end
      fault_clr = 1'b0;
      water_ok = 1'b0;
      type_of_irrigation_state = 3'b010;
      @(negedge clk);
      checks++;
      if (obs !== V_FLT) begin
         errors++;
         $display("FAIL dry_start got=%b exp=%b", obs, V_FLT);
      end
      type_of_irrigation_state = 3'b000;
      water_ok = 1'b1;
      fault_clr = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== V_IDLE) begin
         errors++;
         $display("FAIL dry_clear got=%b exp=%b", obs, V_IDLE);
      end
      fault_clr = 1'b0;
      type_of_irrigation_state = 3'b100;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== V_SPR) begin
            errors++;
            $display("FAIL type_change_spr[%0d] got=%b exp=%b", i, obs, V_SPR);
         end
         type_of_irrigation_state = 3'b010;
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== V_OFF) begin
            errors++;
            $display("FAIL type_change_hold[%0d] got=%b exp=%b", i, obs, V_OFF);
         end
         type_of_irrigation_state = 3'b000;
      end
      @(negedge clk);
      checks++;
      if (obs !== V_IDLE) begin
         errors++;
         $display("FAIL type_change_idle got=%b exp=%b", obs, V_IDLE);
      end
   endtask

   task automatic test_reset_mid_run();
      type_of_irrigation_state = 3'b100;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== V_SPR) begin
            errors++;
            $display("FAIL rst_spr[%0d] got=%b exp=%b", i, obs, V_SPR);
         end
         type_of_irrigation_state = 3'b000;
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== V_IDLE) begin
         errors++;
         $display("FAIL async_reset got=%b exp=%b", obs, V_IDLE);
      end
`ifdef IRR_RUN_COUNTER_EN
      checks++;
      if (run_count !== 8'd0) begin
         errors++;
         $display("FAIL run_count_reset got=%0d exp=0", run_count);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== V_IDLE) begin
         errors++;
         $display("FAIL reset_release got=%b exp=%b", obs, V_IDLE);
      end
   endtask

`ifdef IRR_RUN_COUNTER_EN
   task automatic test_run_counter();
      for (int r = 0; r < 3; r++) begin
         type_of_irrigation_state = 3'b100;
         @(negedge clk);
         type_of_irrigation_state = 3'b000;
         repeat (20) @(negedge clk);
      end
      checks++;
      if (run_count !== 8'd3) begin
         errors++;
         $display("FAIL run_count_three got=%0d exp=3", run_count);
      end
      type_of_irrigation_state = 3'b100;
      @(negedge clk);
      type_of_irrigation_state = 3'b000;
      water_ok = 1'b0;
      @(negedge clk);
      water_ok = 1'b1;
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      checks++;
      if (run_count !== 8'd3 || obs !== V_IDLE) begin
         errors++;
         $display("FAIL run_count_fault got=%0d/%b exp=3/%b", run_count, obs, V_IDLE);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_sprinkler();
      test_mix();
      test_drip_fault();
      test_expiry_fault();
      test_bad_type();
      test_reset_mid_run();
`ifdef IRR_RUN_COUNTER_EN
      test_run_counter();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
